// File: rtl/ipv4_rx_head_fsm_pkg.sv
// Shared types, IPv4 header constants and header word indices for the receive
// header sequencer and the address matchers that sit beside it.
package ipv4_rx_head_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA,
        DISCARD
    } ipv4_rx_fsm_e;

    localparam logic [3:0]  IPV4_VERSION    = 4'd4;
    localparam logic [3:0]  IPV4_IHL_MIN    = 4'd5;
    localparam logic [15:0] IPV4_HEAD_BYTES = 16'd20;

    // Word positions inside the 20-byte header, as seen on the 16-bit stream.
    localparam int IDX_VER     = 0;
    localparam int IDX_LEN     = 1;
    localparam int IDX_PROTO   = 4;
    localparam int IDX_SRC_MSB = 6;
    localparam int IDX_SRC_LSB = 7;
    localparam int IDX_DST_MSB = 8;
    localparam int IDX_DST_LSB = 9;

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

endpackage

// File: rtl/ipv4_rx_head_fsm_if.sv
// Stream, matcher and payload signals between the upstream MAC, the header
// sequencer and the downstream consumers.
interface ipv4_rx_head_fsm_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              start_i;
    logic              cancel_i;
    logic              match_fail_i;
    logic [IDX_W-1:0]  idx_o;
    logic              fsm_idle_v_o;
    logic              fsm_head_v_o;
    logic              head_ok_o;
    logic [15:0]       len_o;
    logic              data_v_o;
    logic [DATA_W-1:0] data_o;
    logic              data_last_o;
    logic              data_odd_o;
    logic              discard_o;

    modport master (
        output valid_i, data_i, start_i, cancel_i, match_fail_i,
        input  idx_o, fsm_idle_v_o, fsm_head_v_o, head_ok_o, len_o,
               data_v_o, data_o, data_last_o, data_odd_o, discard_o
    );

    modport slave (
        input  valid_i, data_i, start_i, cancel_i, match_fail_i,
        output idx_o, fsm_idle_v_o, fsm_head_v_o, head_ok_o, len_o,
               data_v_o, data_o, data_last_o, data_odd_o, discard_o
    );

endinterface

// File: rtl/ipv4_csum.sv
// Ones' complement header checksum accumulator; only used when
// IPV4_CSUM_CHECK_EN is defined.
module ipv4_csum
    import ipv4_rx_head_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] data_i,
    output logic        ok_o
);

    logic [15:0] acc_q;
    logic [15:0] base;
    logic [15:0] sum;

    // ok_o already includes the word on data_i, so the verdict is ready in the
    // same cycle the last header word is presented.
    always_comb begin
        base = clr_i ? 16'd0 : acc_q;
        sum  = ones_add(base, data_i);
        ok_o = (sum == 16'hFFFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 16'd0;
        end else if (en_i) begin
            acc_q <= sum;
        end else if (clr_i) begin
            acc_q <= 16'd0;
        end
    end

endmodule

// File: rtl/ipv4_rx_head_fsm.sv
// Receive-side IPv4 header sequencer: header index/strobes for the matchers,
// header validation, payload forwarding. Define IPV4_CSUM_CHECK_EN to check the header checksum.
module ipv4_rx_head_fsm
    import ipv4_rx_head_fsm_pkg::*;
#(
    parameter int          DATA_W     = 16,
    parameter int          IDX_W      = 5,
    parameter logic [7:0]  PROTOCOL   = 8'd17,
    parameter int          HEAD_WORDS = 10
) (
    input  logic clk,
    input  logic reset,
    ipv4_rx_head_fsm_if.slave bus
);

    ipv4_rx_fsm_e     state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      rem_q, rem_d;
    logic             discard_q, discard_d;

    logic [DATA_W-1:0] word;
    logic              sof;
    logic [IDX_W-1:0]  idx;
    logic              head_v;
    logic              hdr_word;
    logic              last_head;
    logic              field_bad;
    logic              head_fail;
    logic              csum_ok;
    logic              pay_last;
    logic              head_ok;
    logic              data_v;
    logic              data_last;
    logic              data_odd;

    assign word      = bus.data_i;
    assign sof       = bus.valid_i & bus.start_i;
    assign idx       = sof ? '0 : cnt_q;
    assign head_v    = (state_q == HEAD) | sof;
    assign hdr_word  = sof | ((state_q == HEAD) & bus.valid_i);
    assign last_head = (idx == IDX_W'(HEAD_WORDS - 1));
    assign pay_last  = (rem_q <= 16'd2);

`ifdef IPV4_CSUM_CHECK_EN
    ipv4_csum u_csum (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (sof),
        .en_i   (hdr_word),
        .data_i (word[15:0]),
        .ok_o   (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    // Header field checks only look at a word actually on the bus; a matcher
    // fail counts whenever the matchers are told a header word is in flight.
    always_comb begin
        field_bad = 1'b0;
        if (hdr_word) begin
            if ((idx == IDX_W'(IDX_VER)) &&
                ((word[15:12] != IPV4_VERSION) || (word[11:8] != IPV4_IHL_MIN)))
                field_bad = 1'b1;
            if ((idx == IDX_W'(IDX_LEN)) && (word[15:0] < IPV4_HEAD_BYTES))
                field_bad = 1'b1;
            if ((idx == IDX_W'(IDX_PROTO)) && (word[7:0] != PROTOCOL))
                field_bad = 1'b1;
            if (last_head && !csum_ok)
                field_bad = 1'b1;
        end
        head_fail = field_bad | (head_v & bus.match_fail_i);
    end

    // Cancel beats a new start, which beats the per-state checks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        rem_d     = rem_q;
        discard_d = 1'b0;
        head_ok   = 1'b0;
        data_v    = 1'b0;
        data_last = 1'b0;
        data_odd  = 1'b0;

        if (bus.cancel_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            discard_d = (state_q == HEAD) | (state_q == DATA);
        end else if (sof) begin
            discard_d = (state_q == HEAD) | (state_q == DATA);
            if (head_fail) begin
                state_d   = DISCARD;
                cnt_d     = '0;
                discard_d = 1'b1;
            end else begin
                state_d = HEAD;
                cnt_d   = IDX_W'(1);
            end
        end else begin
            case (state_q)
                HEAD: begin
                    if (head_fail) begin
                        state_d   = DISCARD;
                        cnt_d     = '0;
                        discard_d = 1'b1;
                    end else if (bus.valid_i) begin
                        cnt_d = cnt_q + IDX_W'(1);
                        if (idx == IDX_W'(IDX_LEN))
                            len_d = word[15:0] - IPV4_HEAD_BYTES;
                        if (last_head) begin
                            head_ok = 1'b1;
                            cnt_d   = '0;
                            rem_d   = len_q;
                            state_d = (len_q == 16'd0) ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (bus.valid_i) begin
                        data_v    = 1'b1;
                        data_last = pay_last;
                        data_odd  = (rem_q == 16'd1);
                        rem_d     = rem_q - 16'd2;
                        if (pay_last)
                            state_d = IDLE;
                    end
                end
                DISCARD: begin
                    if (!bus.valid_i)
                        state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= 16'd0;
            rem_q     <= 16'd0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            discard_q <= discard_d;
        end
    end

    assign bus.idx_o        = idx;
    assign bus.fsm_idle_v_o = (state_q == IDLE);
    assign bus.fsm_head_v_o = head_v;
    assign bus.head_ok_o    = head_ok;
    assign bus.len_o        = len_q;
    assign bus.data_v_o     = data_v;
    assign bus.data_o       = data_v ? word : '0;
    assign bus.data_last_o  = data_last;
    assign bus.data_odd_o   = data_odd;
    assign bus.discard_o    = discard_q;

endmodule

// File: tb/tb_ipv4_rx_head_fsm.sv
// Directed bench for ipv4_rx_head_fsm: a cycle table of accepted/rejected
// frames followed by hand-written multi-cycle corner cases.
module tb_ipv4_rx_head_fsm;

    localparam int X = -1;

    typedef struct {
        logic        valid;
        logic        start;
        logic        cancel;
        logic        mf;
        logic [15:0] data;
        int idx, idle, head, ok, dv, last, odd, disc, len, dout;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] frm [10];
    vec_t tbl [$];

    always #5 clk = ~clk;

    ipv4_rx_head_fsm_if #(.DATA_W(16), .IDX_W(5)) bus ();

    ipv4_rx_head_fsm #(
        .DATA_W(16), .IDX_W(5), .PROTOCOL(8'd17), .HEAD_WORDS(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic v, input logic s, input logic c, input logic m,
                                input logic [15:0] d, input int idx, input int idle,
                                input int head, input int ok, input int dv, input int last,
                                input int odd, input int disc, input int len, input int dout);
        vec_t r;
        r.valid = v; r.start = s; r.cancel = c; r.mf = m; r.data = d;
        r.idx = idx; r.idle = idle; r.head = head; r.ok = ok; r.dv = dv;
        r.last = last; r.odd = odd; r.disc = disc; r.len = len; r.dout = dout;
        return r;
    endfunction

    task automatic cmp(input string tag, input string name, input int act, input int exp);
        if (exp >= 0) begin
            checks++;
            if (act != exp) begin
                errors++;
                $display("[TB] FAIL %s.%s got %0d expected %0d", tag, name, act, exp);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.valid_i      = v.valid;
        bus.start_i      = v.start;
        bus.cancel_i     = v.cancel;
        bus.match_fail_i = v.mf;
        bus.data_i       = v.data;
        #2;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        cmp(tag, "idx",  int'(bus.idx_o),        v.idx);
        cmp(tag, "idle", int'(bus.fsm_idle_v_o), v.idle);
        cmp(tag, "head", int'(bus.fsm_head_v_o), v.head);
        cmp(tag, "ok",   int'(bus.head_ok_o),    v.ok);
        cmp(tag, "dv",   int'(bus.data_v_o),     v.dv);
        cmp(tag, "last", int'(bus.data_last_o),  v.last);
        cmp(tag, "odd",  int'(bus.data_odd_o),   v.odd);
        cmp(tag, "disc", int'(bus.discard_o),    v.disc);
        cmp(tag, "len",  int'(bus.len_o),        v.len);
        cmp(tag, "dout", int'(bus.data_o),       v.dout);
    endtask

    task automatic step(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(v, tag);
    endtask

    // Builds a 10-word UDP-style header with a correct checksum in word 5.
    task automatic make_hdr(input logic [15:0] w0, input logic [15:0] tlen, input logic [7:0] proto);
        logic [31:0] s;
        frm = '{w0, tlen, 16'h0000, 16'h4000, {8'h40, proto}, 16'h0000,
                16'hC0A8, 16'h0001, 16'hC0A8, 16'h0002};
        s = 32'd0;
        for (int i = 0; i < 10; i++) begin
            s = s + {16'd0, frm[i]};
            s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        end
        frm[5] = ~s[15:0];
    endtask

    task automatic push_head(input logic [15:0] w0, input logic [15:0] tlen, input logic [7:0] proto,
                             input int len_pre, input int len_post, input int ok9);
        make_hdr(w0, tlen, proto);
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1'b1, (i == 0), 1'b0, 1'b0, frm[i], i, (i == 0) ? 1 : 0, 1,
                             (i == 9) ? ok9 : 0, 0, 0, 0, 0, (i <= 1) ? len_pre : len_post, X));
    endtask

    task automatic hdr_words(input int from, input int upto, input int ok9, input string tag);
        for (int i = from; i <= upto; i++)
            step(mk(1'b1, (i == 0), 1'b0, 1'b0, frm[i], i, X, 1, (i == 9) ? ok9 : 0,
                    0, 0, 0, X, X, X), $sformatf("%s.w%0d", tag, i));
    endtask

    task automatic payload(input int n, input int len_bytes, input string tag);
        logic [15:0] pw;
        int rem;
        for (int k = 0; k < n; k++) begin
            pw  = 16'hC000 + 16'(k);
            rem = len_bytes - 2 * k;
            step(mk(1'b1, 1'b0, 1'b0, 1'b0, pw, X, 0, 0, 0, 1, (rem <= 2) ? 1 : 0,
                    (rem == 1) ? 1 : 0, 0, len_bytes, int'(pw)), $sformatf("%s.p%0d", tag, k));
        end
    endtask

    task automatic idle_row(input int idle, input int disc, input string tag);
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, X, idle, 0, 0, 0, 0, 0, disc, X, X), tag);
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.cancel_i = 1'b0;
        bus.match_fail_i = 1'b0; bus.data_i = 16'h0000;

        #12;
        checkOutput(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
        @(negedge clk);
        reset = 1'b0;

        // Cycle table: 10-byte frame with a payload stall, 5-byte odd frame,
        // zero-payload frame, then an IHL=6 header that must be dropped.
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 1, 0, 0, 0, 0, 0, 0, 0, X));
        push_head(16'h4500, 16'h001E, 8'h11, 0, 10, 1);
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hA001, X, 0, 0, 0, 1, 0, 0, 0, 10, 16'hA001));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hA002, X, 0, 0, 0, 1, 0, 0, 0, 10, 16'hA002));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, X, 0, 0, 0, 0, 0, 0, 0, 10, X));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hA003, X, 0, 0, 0, 1, 0, 0, 0, 10, 16'hA003));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hA004, X, 0, 0, 0, 1, 0, 0, 0, 10, 16'hA004));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hA005, X, 0, 0, 0, 1, 1, 0, 0, 10, 16'hA005));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 1, 0, 0, 0, 0, 0, 0, 10, X));
        push_head(16'h4500, 16'h0019, 8'h11, 10, 5, 1);
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hB001, X, 0, 0, 0, 1, 0, 0, 0, 5, 16'hB001));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hB002, X, 0, 0, 0, 1, 0, 0, 0, 5, 16'hB002));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hB003, X, 0, 0, 0, 1, 1, 1, 0, 5, 16'hB003));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 1, 0, 0, 0, 0, 0, 0, 5, X));
        push_head(16'h4500, 16'h0014, 8'h11, 5, 0, 1);
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 1, 0, 0, 0, 0, 0, 0, 0, X));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h4600, 0, 1, 1, 0, 0, 0, 0, 0, X, X));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h001E, X, 0, 0, 0, 0, 0, 0, 1, X, X));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 0, 0, 0, 0, 0, 0, 0, X, X));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 1, 0, 0, 0, 0, 0, 0, X, X));
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("tbl%0d", i));

        // Wrong protocol: dropped at idx 4, nothing forwarded afterwards.
        make_hdr(16'h4500, 16'h001E, 8'h06);
        hdr_words(0, 4, 0, "proto");
        for (int i = 5; i < 13; i++)
            step(mk(1'b1, 1'b0, 1'b0, 1'b0, (i < 10) ? frm[i] : 16'h1234, X, 0, 0, 0, 0, 0, X,
                    (i == 5) ? 1 : 0, X, X), $sformatf("proto.s%0d", i));
        idle_row(0, 0, "proto.end");
        idle_row(1, 0, "proto.idle");

        // Matcher fail at idx 7, then a back-to-back start out of DISCARD.
        make_hdr(16'h4500, 16'h001E, 8'h11);
        hdr_words(0, 6, 0, "mf");
        step(mk(1'b1, 1'b0, 1'b0, 1'b1, frm[7], 7, 0, 1, 0, 0, 0, 0, 0, X, X), "mf.w7");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, frm[8], X, 0, 0, 0, 0, 0, 0, 1, X, X), "mf.w8");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, frm[9], X, 0, 0, 0, 0, 0, 0, 0, X, X), "mf.w9");
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, frm[0], 0, 0, 1, 0, 0, 0, 0, X, X, X), "mf.restart");
        hdr_words(1, 9, 1, "mf.next");
        payload(5, 10, "mf.pay");
        idle_row(1, 0, "mf.idle");

        // Cancel on payload word 2.
        hdr_words(0, 9, 1, "cancel");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hD001, X, 0, 0, 0, 1, 0, 0, 0, 10, 16'hD001), "cancel.p0");
        step(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'hD002, X, X, X, 0, 0, 0, 0, 0, X, X), "cancel.p1");
        idle_row(1, 1, "cancel.after");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'hD003, X, 1, 0, 0, 0, 0, 0, 0, X, X), "cancel.stray");

        // 3-cycle valid gaps inside the header after idx 2 and idx 6.
        for (int i = 0; i < 10; i++) begin
            step(mk(1'b1, (i == 0), 1'b0, 1'b0, frm[i], i, X, 1, (i == 9) ? 1 : 0, 0, 0, 0, 0, X, X),
                 $sformatf("gap.w%0d", i));
            if (i == 2 || i == 6)
                for (int g = 0; g < 3; g++)
                    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, i + 1, 0, 1, 0, 0, 0, 0, 0, X, X),
                         $sformatf("gap.h%0d.%0d", i, g));
        end
        payload(5, 10, "gap.pay");
        idle_row(1, 0, "gap.idle");

        // Corrupted checksum field.
        make_hdr(16'h4500, 16'h001E, 8'h11);
        frm[5] = frm[5] ^ 16'h0001;
`ifdef IPV4_CSUM_CHECK_EN
        hdr_words(0, 9, 0, "csum");
        step(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, X, 0, 0, 0, 0, 0, 0, 1, X, X), "csum.drop");
        idle_row(1, 0, "csum.idle");
`else
        hdr_words(0, 9, 1, "csum");
        payload(5, 10, "csum.pay");
        idle_row(1, 0, "csum.idle");
`endif

        // New start on payload word 3 restarts the header and drops the old frame.
        make_hdr(16'h4500, 16'h001E, 8'h11);
        hdr_words(0, 9, 1, "restart");
        payload(2, 10, "restart.pay");
        make_hdr(16'h4500, 16'h0019, 8'h11);
        step(mk(1'b1, 1'b1, 1'b0, 1'b0, frm[0], 0, 0, 1, 0, 0, 0, 0, 0, 10, X), "restart.sof");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, frm[1], 1, 0, 1, 0, 0, 0, 0, 1, 10, X), "restart.w1");
        hdr_words(2, 9, 1, "restart.new");
        payload(3, 5, "restart.newpay");
        idle_row(1, 0, "restart.idle");

        // Reset in the middle of a header.
        make_hdr(16'h4500, 16'h001E, 8'h11);
        hdr_words(0, 4, 0, "rst");
        @(negedge clk);
        reset = 1'b1;
        bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.data_i = 16'h0000;
        #2;
        checkOutput(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst.mid");
        @(negedge clk);
        reset = 1'b0;
        idle_row(1, 0, "rst.after");
        idle_row(1, 0, "rst.after2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
